// File: rtl/axis_dw_0_10.sv
// AXI4-Stream word-granular down-converter: 16-word input beats repacked into
// 10-word output beats through a 32-word shift buffer, preserving word order.
module axis_dw_0_10 #(
    parameter int DATA_WIDTH = 16,
    parameter int S_WORDS    = 16,
    parameter int M_WORDS    = 10,
    parameter int BUF_WORDS  = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [S_WORDS*DATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [M_WORDS*DATA_WIDTH-1:0] m_axis_tdata
);

    localparam int CW = $clog2(BUF_WORDS + 1);

    logic [BUF_WORDS*DATA_WIDTH-1:0] buf_q;
    logic [BUF_WORDS*DATA_WIDTH-1:0] buf_next;
    logic [CW-1:0]                   count;
    logic [CW-1:0]                   count_next;
    logic [CW-1:0]                   wr_base;
    logic                            rst_done;
    logic                            push;
    logic                            pop;

    // Input readiness depends only on registered state, so no path from either valid/ready input.
    assign s_axis_tready = rst_done && (count <= CW'(BUF_WORDS - S_WORDS));
    assign m_axis_tvalid = (count >= CW'(M_WORDS));
    assign m_axis_tdata  = buf_q[M_WORDS*DATA_WIDTH-1:0];

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    // Shift out the popped beat first, then drop the new words in right behind the survivors.
    always_comb begin
        wr_base  = pop ? (count - CW'(M_WORDS)) : count;
        buf_next = pop ? (buf_q >> (M_WORDS * DATA_WIDTH)) : buf_q;
        if (push) begin
            for (int i = 0; i < BUF_WORDS; i++) begin
                for (int j = 0; j < S_WORDS; j++) begin
                    if (CW'(i) == wr_base + CW'(j)) begin
                        buf_next[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(S_WORDS);
            2'b01:   count_next = count - CW'(M_WORDS);
            2'b11:   count_next = count + CW'(S_WORDS) - CW'(M_WORDS);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count    <= '0;
            rst_done <= 1'b0;
        end else begin
            count    <= count_next;
            rst_done <= 1'b1;
        end
    end

    // Buffer contents are meaningless without count, so they are left unreset.
    always_ff @(posedge aclk) begin
        buf_q <= buf_next;
    end

endmodule

// File: tb/tb_axis_dw_0_10.sv
// Scoreboard bench for axis_dw_0_10: accepted input words are queued, and a
// negedge monitor pops and compares every output beat.
module tb_axis_dw_0_10;

    localparam int DW = 16;
    localparam int SW = 16;
    localparam int MW = 10;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [SW*DW-1:0] s_axis_tdata = '0;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [MW*DW-1:0] m_axis_tdata;

    int errors = 0;
    int checks = 0;
    int accepted_beats = 0;
    int beats_seen = 0;
    logic [DW-1:0] exp_q[$];
    logic            held = 1'b0;
    logic [MW*DW-1:0] held_data = '0;
    bit              rand_done = 1'b0;

    axis_dw_0_10 dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [MW*DW-1:0] act, input logic [MW*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [SW*DW-1:0] make_beat(input int first);
        logic [SW*DW-1:0] b;
        for (int i = 0; i < SW; i++) b[i*DW +: DW] = DW'(first + i);
        return b;
    endfunction

    function automatic logic [SW*DW-1:0] rand_beat();
        logic [SW*DW-1:0] b;
        for (int i = 0; i < SW; i++) b[i*DW +: DW] = DW'($urandom);
        return b;
    endfunction

    function automatic logic [MW*DW-1:0] expect_words(input int first);
        logic [MW*DW-1:0] b;
        for (int i = 0; i < MW; i++) b[i*DW +: DW] = DW'(first + i);
        return b;
    endfunction

    // Holds tvalid until the beat is taken, then queues its words as expected output.
    task automatic applyStimulus(input logic [SW*DW-1:0] data);
        int  waited = 0;
        bit  done = 1'b0;
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        while (!done) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                for (int i = 0; i < SW; i++) exp_q.push_back(data[i*DW +: DW]);
                accepted_beats++;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 2000) begin
                    checkOutput("accept_timeout", 160'(waited), 160'(0));
                    done = 1'b1;
                end
            end
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge aclk);
            checkOutput("rst_tready", 160'(s_axis_tready), 160'(0));
            checkOutput("rst_tvalid", 160'(m_axis_tvalid), 160'(0));
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("post_rst_tready", 160'(s_axis_tready), 160'(1));
        checkOutput("post_rst_tvalid", 160'(m_axis_tvalid), 160'(0));
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int residue);
        int budget = 1000;
        while (exp_q.size() != residue && budget > 0) begin
            @(posedge aclk);
            #1;
            budget--;
        end
        repeat (3) @(posedge aclk);
        #1;
        checkOutput(name, 160'(exp_q.size()), 160'(residue));
    endtask

    // Monitor: compares every output handshake against the queue and checks stability under stall.
    always @(negedge aclk) begin
        if (!aresetn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("hold_valid", 160'(m_axis_tvalid), 160'(1));
                checkOutput("hold_data", m_axis_tdata, held_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() < MW) begin
                    checkOutput("unexpected_beat", 160'(exp_q.size()), 160'(MW));
                end else begin
                    logic [MW*DW-1:0] exp;
                    for (int i = 0; i < MW; i++) exp[i*DW +: DW] = exp_q.pop_front();
                    checkOutput("beat_data", m_axis_tdata, exp);
                end
                beats_seen++;
            end
            held      = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
        end
    end

    initial begin
        int base_beats;
        #1;
        $display("[TB] test 1: reset");
        do_reset();

        $display("[TB] test 2: single beat");
        m_axis_tready = 1'b1;
        applyStimulus(make_beat(0));
        @(negedge aclk);
        checkOutput("latency_valid", 160'(m_axis_tvalid), 160'(1));
        checkOutput("first_beat", m_axis_tdata, expect_words(0));
        @(posedge aclk);
        @(negedge aclk);
        checkOutput("residue_idle", 160'(m_axis_tvalid), 160'(0));
        @(posedge aclk);
        #1;
        wait_drain("residue6", 6);

        $display("[TB] test 3: 100 beats streaming");
        do_reset();
        m_axis_tready = 1'b1;
        base_beats = beats_seen;
        for (int k = 0; k < 100; k++) applyStimulus(make_beat(k * 16));
        wait_drain("stream_drain", 0);
        checkOutput("stream_beats", 160'(beats_seen - base_beats), 160'(160));

        $display("[TB] test 4: backpressure");
        do_reset();
        m_axis_tready  = 1'b0;
        accepted_beats = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) applyStimulus(make_beat(k * 16));
            end
            begin
                repeat (20) @(negedge aclk);
                checkOutput("stall_beats", 160'(accepted_beats), 160'(2));
                checkOutput("stall_tready", 160'(s_axis_tready), 160'(0));
                checkOutput("stall_data", m_axis_tdata, expect_words(0));
                @(posedge aclk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_drain("bp_drain", 4);

        $display("[TB] test 5: random handshakes");
        do_reset();
        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 1000; b++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        @(posedge aclk);
                        #1;
                    end
                    applyStimulus(rand_beat());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge aclk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain("rand_drain", 0);

        $display("[TB] test 6: mid-stream reset");
        do_reset();
        m_axis_tready = 1'b0;
        applyStimulus(make_beat(0));
        applyStimulus(make_beat(16));
        @(negedge aclk);
        checkOutput("pre_reset_valid", 160'(m_axis_tvalid), 160'(1));
        #1;
        aresetn = 1'b0;
        #1;
        checkOutput("async_tvalid", 160'(m_axis_tvalid), 160'(0));
        checkOutput("async_tready", 160'(s_axis_tready), 160'(0));
        @(posedge aclk);
        #1;
        do_reset();
        m_axis_tready = 1'b1;
        applyStimulus(make_beat(0));
        wait_drain("pre_reset_residue", 6);
        do_reset();
        applyStimulus(make_beat(100));
        @(negedge aclk);
        checkOutput("after_reset_beat", m_axis_tdata, expect_words(100));
        @(posedge aclk);
        #1;
        wait_drain("after_reset_residue", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
